// File: rtl/fp_arith_pkg.sv
// fp_arith_pkg: shared widths and state encoding for the FP mantissa datapath.
`default_nettype none

package fp_arith_pkg;
  localparam int MW = 24;
  localparam int PW = 2 * MW;
  localparam int CW = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

`default_nettype wire

// File: rtl/arith_add.sv
// arith_add: W-bit unsigned adder with carry-out.
`default_nettype none

module arith_add #(
  parameter int W = 48
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         co
);
  assign {co, sum} = {1'b0, a} + {1'b0, b};
endmodule

`default_nettype wire

// File: rtl/fp_mant_mult_ctrl.sv
// fp_mant_mult_ctrl: sequencing FSM and iteration counter for the shift-add multiplier.
`default_nettype none

module fp_mant_mult_ctrl
  import fp_arith_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic load,
  output logic step,
  output logic finish,
  output logic busy,
  output logic done
);
  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      cnt <= '0;
    else if (load) cnt <= '0;
    else if (step) cnt <= cnt + 1'b1;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == CW'(MW - 1)) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
endmodule

`default_nettype wire

// File: rtl/fp_mant_mult_seq.sv
// fp_mant_mult_seq: radix-2 shift-and-add 24x24 mantissa multiplier, one partial product per cycle.
`default_nettype none

module fp_mant_mult_seq
  import fp_arith_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [MW-1:0] a,
  input  logic [MW-1:0] b,
  output logic          busy,
  output logic          done,
  output logic [PW-1:0] p
);
  logic          load;
  logic          step;
  logic          finish;
  logic [PW-1:0] mcand;
  logic [MW-1:0] mplier;
  logic [PW-1:0] acc;
  logic [PW-1:0] add_sum;
  logic [PW-1:0] acc_nxt;
  logic          unused_carry;

  fp_mant_mult_ctrl u_ctrl (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .load   (load),
    .step   (step),
    .finish (finish),
    .busy   (busy),
    .done   (done)
  );

  // Carry-out cannot be set while accumulating: every partial sum stays below a*b < 2^PW.
  arith_add #(.W(PW)) u_add (
    .a   (acc),
    .b   (mcand),
    .sum (add_sum),
    .co  (unused_carry)
  );

  assign acc_nxt = mplier[0] ? add_sum : acc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      p      <= '0;
    end else if (load) begin
      mcand  <= {{MW{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
    end else if (step) begin
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      acc    <= acc_nxt;
      if (finish) p <= acc_nxt;
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_fp_mant_mult_seq.sv
// tb_fp_mant_mult_seq: directed and randomized checks of the sequential mantissa multiplier.
`default_nettype none

module tb_fp_mant_mult_seq;
  logic        clk;
  logic        rst;
  logic        start;
  logic [23:0] a;
  logic [23:0] b;
  logic        busy;
  logic        done;
  logic [47:0] p;

  int          checks;
  int          failures;
  logic [47:0] exp_p;

  fp_mant_mult_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference product from plain unsigned arithmetic.
  function automatic logic [47:0] ref_mul(input logic [23:0] x, input logic [23:0] y);
    longint unsigned r;
    r = longint'(x) * longint'(y);
    return r[47:0];
  endfunction

  // Entered #1 after a rising edge with the DUT idle; returns #1 after the edge that re-enters IDLE.
  task automatic run(input logic [23:0] ra, input logic [23:0] rb, input bit pulse_busy);
    logic [47:0] old_p;
    logic [47:0] want;
    int          lat;
    old_p = exp_p;
    want  = ref_mul(ra, rb);
    start = 1'b1;
    a     = ra;
    b     = rb;
    @(posedge clk); #1;
    start = 1'b0;
    a     = 24'($urandom);
    b     = 24'($urandom);
    lat   = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (done) break;
      lat++;
      check("run_busy", {47'b0, busy}, 48'd1);
      check("p_hold", p, old_p);
      check("carry_out", {47'b0, dut.unused_carry}, 48'd0);
      if (pulse_busy && (cyc == 2 || cyc == 9 || cyc == 17)) begin
        start = 1'b1;
        a     = 24'hFFFFFF;
        b     = 24'hFFFFFF;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    check("latency", 48'(lat), 48'd24);
    check("done_busy", {47'b0, busy}, 48'd1);
    check("product", p, want);
    exp_p = want;
    if (pulse_busy) begin
      start = 1'b1;
      a     = 24'hFFFFFF;
      b     = 24'hFFFFFF;
    end
    @(posedge clk); #1;
    start = 1'b0;
    check("done_single", {47'b0, done}, 48'd0);
    check("idle_after", {47'b0, busy}, 48'd0);
    check("p_after", p, want);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_p    = '0;
    rst      = 1'b0;
    start    = 1'b1;
    a        = 24'hFFFFFF;
    b        = 24'hFFFFFF;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {47'b0, busy}, 48'd0);
    check("rst_done", {47'b0, done}, 48'd0);
    check("rst_p", p, 48'h0);
    start = 1'b0;
    rst   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("idle_busy", {47'b0, busy | done}, 48'd0);
      check("idle_p", p, 48'h0);
    end

    run(24'hFFFFFF, 24'hFFFFFF, 1'b0);
    check("max_const", p, 48'hFFFFFE000001);
    run(24'hC00000, 24'hC00000, 1'b0);
    check("norm_const", p, 48'h900000000000);
    run(24'h000001, 24'h800000, 1'b0);
    check("ident_const", p, 48'h000000800000);
    run(24'h000000, 24'h123456, 1'b0);
    check("zero_const", p, 48'h0);
    run(24'h000007, 24'h00000B, 1'b1);

    start = 1'b1;
    a     = 24'h000003;
    b     = 24'h000005;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    exp_p = '0;
    check("abort_busy", {47'b0, busy}, 48'd0);
    check("abort_done", {47'b0, done}, 48'd0);
    check("abort_p", p, 48'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("abort_nodone", {47'b0, done}, 48'd0);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    run(24'h000003, 24'h000005, 1'b0);
    check("abort_restart", p, 48'h00000000000F);

    for (int i = 0; i < 8; i++) begin
      run(24'($urandom), 24'($urandom), bit'(i % 2));
    end
    run(24'($urandom_range(1, 255)), 24'hFFFFFF, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
